// File: rtl/display_pkg.sv
// display_pkg: shared segment glyph constants and scan state type for the 7-segment scanner
package display_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;
   typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: nibble -> active-low {a..g} segment pattern
//   nibble in 4, seg_n out 7 (bit6 = a)
//   HEX_DIGITS_EN defined: 10..15 show A,b,C,d,E,F; otherwise they show blank
module seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);
   always_comb
      case (nibble)
         4'h0: seg_n = SEG_0;
         4'h1: seg_n = SEG_1;
         4'h2: seg_n = SEG_2;
         4'h3: seg_n = SEG_3;
         4'h4: seg_n = SEG_4;
         4'h5: seg_n = SEG_5;
         4'h6: seg_n = SEG_6;
         4'h7: seg_n = SEG_7;
         4'h8: seg_n = SEG_8;
         4'h9: seg_n = SEG_9;
`ifdef HEX_DIGITS_EN
         4'hA: seg_n = SEG_A;
         4'hB: seg_n = SEG_B;
         4'hC: seg_n = SEG_C;
         4'hD: seg_n = SEG_D;
         4'hE: seg_n = SEG_E;
         4'hF: seg_n = SEG_F;
`else
         4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg_n = SEG_BLANK;
`endif
      endcase
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 7-segment driver with anti-ghost blanking
//   clock/reset      rising-edge clock, synchronous active-high reset
//   load, value_in   capture packed nibbles (nibble 0 = rightmost digit) into the shadow register
//   lzb              leading-zero blanking enable
//   seg_n, an_n      active-low segments {a..g} and digit anodes, registered
//   frame_start      one-cycle pulse with the first output cycle of the digit-0 slot
//   HEX_DIGITS_EN    selects A..F glyphs inside seg_decoder
module seven_seg_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    lzb,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_start
);
   localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
   logic [PW-1:0]           presc, presc_nxt;
   logic [DW-1:0]           digit_idx, digit_nxt;
   logic [4*NUM_DIGITS-1:0] shadow;
   scan_state_t             state, state_nxt;
   logic [NUM_DIGITS-1:0]   lead_zero, an_d;
   logic [3:0]              nibble;
   logic [6:0]              glyph, seg_d;
   logic                    wrap, blank_digit;
   always_ff @(posedge clock)
      if (reset) begin
         presc     <= '0;
         digit_idx <= '0;
         state     <= BLANK;
      end else begin
         presc     <= presc_nxt;
         digit_idx <= digit_nxt;
         state     <= state_nxt;
      end
   // state follows the upcoming presc so the BLANK/SHOW phase lines up with the slot counter
   always_comb begin
      wrap      = presc == P_LAST;
      presc_nxt = wrap ? '0 : presc + 1'b1;
      digit_nxt = wrap ? (digit_idx == D_LAST ? '0 : digit_idx + 1'b1) : digit_idx;
      state_nxt = presc_nxt < P_BLANK ? BLANK : SHOW;
   end
   always_ff @(posedge clock)
      if (reset) shadow <= '0;
      else if (load) shadow <= value_in;
   // lead_zero[k]: every nibble from k up to the most significant one is zero
   always_comb begin
      lead_zero = '0;
      for (int k = 0; k < NUM_DIGITS; k++) lead_zero[k] = (shadow >> (4 * k)) == '0;
   end
   assign nibble = shadow[{digit_idx, 2'b00} +: 4];
   seg_decoder u_dec (
      .nibble (nibble),
      .seg_n  (glyph)
   );
   always_comb begin
      blank_digit = lzb && digit_idx != '0 && lead_zero[digit_idx];
      seg_d       = state == SHOW && !blank_digit ? glyph : SEG_BLANK;
      an_d        = state == SHOW ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
   end
   always_ff @(posedge clock)
      if (reset) begin
         seg_n       <= SEG_BLANK;
         an_n        <= '1;
         frame_start <= 1'b0;
      end else begin
         seg_n       <= seg_d;
         an_n        <= an_d;
         frame_start <= presc == '0 && digit_idx == '0;
      end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: checks two scanners (BLANK_CYCLES=1 and 0) against a cycle-count model
module tb_seven_seg_scanner;
   logic        clock = 1'b0, reset = 1'b1, load = 1'b0, lzb = 1'b0;
   logic [15:0] value_in = '0;
   logic [6:0]  seg_a, seg_z;
   logic [3:0]  an_a, an_z;
   logic        fs_a, fs_z;
   int          vectors = 0, miscompares = 0;

   always #5 clock = ~clock;

   seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_b1 (
      .clock(clock), .reset(reset), .load(load), .value_in(value_in), .lzb(lzb),
      .seg_n(seg_a), .an_n(an_a), .frame_start(fs_a));
   seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) u_b0 (
      .clock(clock), .reset(reset), .load(load), .value_in(value_in), .lzb(lzb),
      .seg_n(seg_z), .an_n(an_z), .frame_start(fs_z));

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] r;
      r = 7'h7F;
      case (v)
         4'd0: r = ~7'h7E;  4'd1: r = ~7'h30;  4'd2: r = ~7'h6D;  4'd3: r = ~7'h79;
         4'd4: r = ~7'h33;  4'd5: r = ~7'h5B;  4'd6: r = ~7'h5F;  4'd7: r = ~7'h70;
         4'd8: r = ~7'h7F;  4'd9: r = ~7'h7B;
`ifdef HEX_DIGITS_EN
         4'd10: r = 7'b0001000; 4'd11: r = 7'b1100000; 4'd12: r = 7'b0110001;
         4'd13: r = 7'b1000010; 4'd14: r = 7'b0110000; 4'd15: r = 7'b0111000;
`endif
         default: r = 7'h7F;
      endcase
      return r;
   endfunction

   // model: cnt = cycles since reset released; slot/digit follow by division
   int          cnt = 0;
   logic [15:0] msh = '0;
   logic        valid = 1'b0;
   logic [6:0]  e_seg [2];
   logic [3:0]  e_an [2];
   logic        e_fs [2];

   always @(posedge clock) begin
      int p, d, bc;
      logic show;
      p = cnt % 4;
      d = (cnt / 4) % 4;
      for (int b = 0; b < 2; b++) begin
         bc = (b == 0) ? 1 : 0;
         if (reset) begin
            e_seg[b] = 7'h7F; e_an[b] = 4'hF; e_fs[b] = 1'b0;
         end else begin
            show     = cnt != 0 && p >= bc;
            e_an[b]  = show ? ~(4'b1 << d) : 4'hF;
            e_seg[b] = !show ? 7'h7F : (lzb && d > 0 && (msh >> (4 * d)) == 16'h0) ? 7'h7F : glyph(msh[4*d +: 4]);
            e_fs[b]  = p == 0 && d == 0;
         end
      end
      if (reset) begin
         cnt = 0; msh = '0;
      end else begin
         cnt++;
         if (load) msh = value_in;
      end
      valid = 1'b1;
   end

   always @(negedge clock)
      if (valid) begin
         check("seg_b1", seg_a, e_seg[0]);
         check("an_b1",  an_a,  e_an[0]);
         check("fs_b1",  fs_a,  e_fs[0]);
         check("seg_b0", seg_z, e_seg[1]);
         check("an_b0",  an_z,  e_an[1]);
         check("fs_b0",  fs_z,  e_fs[1]);
      end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_fs();
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (fs_a) break;
      end
      check("fs_wait", fs_a, 1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_seg", seg_a, 7'h7F);
         check("rst_an", an_a, 4'hF);
         check("rst_fs", fs_a, 0);
      end
      reset = 1'b0;
      tick(1);
      check("first_fs", fs_a, 1);
      check("first_an", an_a, 4'hF);
      load = 1'b1; value_in = 16'h1234;
      tick(1);
      load = 1'b0;
      wait_fs();
      check("b0_d0_an", an_z, 4'b1110);
      check("b0_d0_seg", seg_z, 7'b1001100);
      tick(1);
      check("d0_an", an_a, 4'b1110);
      check("d0_seg", seg_a, 7'b1001100);
      tick(3);
      check("gap_an", an_a, 4'hF);
      tick(1);
      check("d1_an", an_a, 4'b1101);
      check("d1_seg", seg_a, 7'b0000110);
      tick(4);
      check("d2_an", an_a, 4'b1011);
      check("d2_seg", seg_a, 7'b0010010);
      tick(4);
      check("d3_an", an_a, 4'b0111);
      check("d3_seg", seg_a, 7'b1001111);
      tick(3);
      check("period_fs", fs_a, 1);
      load = 1'b1; value_in = 16'h00A0; lzb = 1'b1;
      tick(1);
      load = 1'b0;
      wait_fs();
      tick(1);
      check("lzb_d0_an", an_a, 4'b1110);
      check("lzb_d0_seg", seg_a, 7'b0000001);
      tick(4);
      check("lzb_d1_an", an_a, 4'b1101);
`ifdef HEX_DIGITS_EN
      check("lzb_d1_seg", seg_a, 7'b0001000);
`else
      check("lzb_d1_seg", seg_a, 7'h7F);
`endif
      tick(4);
      check("lzb_d2_an", an_a, 4'b1011);
      check("lzb_d2_seg", seg_a, 7'h7F);
      tick(4);
      check("lzb_d3_an", an_a, 4'b0111);
      check("lzb_d3_seg", seg_a, 7'h7F);
      lzb = 1'b0;
      wait_fs();
      tick(9);
      load = 1'b1; value_in = 16'h5555;
      tick(1);
      load = 1'b0;
      check("ld_old_seg", seg_z, 7'b0000001);
      check("ld_old_an", an_z, 4'b1011);
      tick(1);
      check("ld_new_seg", seg_z, 7'b0100100);
      check("ld_new_an", an_z, 4'b1011);
      tick(1);
      check("ld_next_an", an_z, 4'b0111);
      wait_fs();
      tick(10);
      reset = 1'b1;
      tick(1);
      check("mid_rst_an", an_a, 4'hF);
      check("mid_rst_seg", seg_a, 7'h7F);
      check("mid_rst_an_b0", an_z, 4'hF);
      reset = 1'b0;
      tick(1);
      check("restart_fs", fs_a, 1);
      check("restart_an", an_a, 4'hF);
      tick(1);
      check("restart_d0_an", an_a, 4'b1110);
      check("restart_d0_seg", seg_a, 7'b0000001);
      tick(8);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
